// File: rtl/timer_dev.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT/PRESCALE registers, one-shot or auto-reload, maskable level irq.
// Optional prescaler compiled in with `define TIMER_PRESCALE_EN.
module timer_dev (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic        pend;
  logic [31:0] preset;
  logic [31:0] count;
  logic        tick;
  logic        wr_ctrl;
  logic        wr_preset;

  assign wr_ctrl   = we && (addr == 2'd0);
  assign wr_preset = we && (addr == 2'd1);

`ifdef TIMER_PRESCALE_EN
  logic [7:0] prescale;
  logic [7:0] pcnt;

  assign tick = (pcnt == prescale);

  // pcnt only advances while the FSM stays in CNT; any other cycle returns it to 0
  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale <= '0;
      pcnt     <= '0;
    end else begin
      if (we && (addr == 2'd3) && be[0])
        prescale <= din[7:0];
      if ((state == CNT) && en && !(tick && (count <= 32'd1)))
        pcnt <= tick ? '0 : pcnt + 8'd1;
      else
        pcnt <= '0;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Later assignments win: hardware EN clear beats the CTRL write, PEND set beats the write clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= '0;
      im     <= 1'b0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
    end else begin
      if (wr_ctrl && be[0]) begin
        en   <= din[0];
        mode <= din[2:1];
        im   <= din[3];
      end
      if (wr_preset) begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (be[i])
            preset[8*i +: 8] <= din[8*i +: 8];
        end
      end
      if (wr_ctrl || wr_preset)
        pend <= 1'b0;

      case (state)
        IDLE: begin
          if (en)
            state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (tick) begin
            if (count > 32'd1) begin
              count <= count - 32'd1;
            end else begin
              count <= '0;
              state <= INT;
              pend  <= 1'b1;
            end
          end
        end
        INT: begin
          if ((mode == 2'b01) && en) begin
            state <= LOAD;
          end else begin
            en    <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign irq = pend & im;

  always_comb begin
    dout = '0;
    case (addr)
      2'd0: dout = {28'd0, im, mode, en};
      2'd1: dout = preset;
      2'd2: dout = count;
      2'd3: begin
`ifdef TIMER_PRESCALE_EN
        dout = {24'd0, prescale};
`else
        dout = '0;
`endif
      end
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_dev.sv
// Scoreboard bench for timer_dev: stimulus queues expected dout/irq, a negedge monitor pops and compares.
module tb_timer_dev;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  addr = '0;
  logic        we = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        irq;
  logic        sample = 1'b0;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t exp_q[$];

  timer_dev dut (
    .clk  (clk),
    .rst  (rst),
    .addr (addr),
    .we   (we),
    .be   (be),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty: sample with no expected entry, dout=%h irq=%b", dout, irq);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (dout !== e.dout || irq !== e.irq) begin
          failures++;
          $display("FAIL %s: got dout=%h irq=%b, expected dout=%h irq=%b",
                   e.name, dout, irq, e.dout, e.irq);
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a;
    din  = d;
    be   = b;
    we   = 1'b1;
    @(posedge clk);
    #1;
    we  = 1'b0;
    be  = '0;
    din = '0;
  endtask

  task automatic chk(input string nm, input logic [1:0] a, input logic [31:0] d, input logic i);
    exp_t e;
    e.name = nm;
    e.dout = d;
    e.irq  = i;
    addr = a;
    exp_q.push_back(e);
    sample = 1'b1;
    @(negedge clk);
    #1;
    sample = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int unsigned ar_pat[5] = '{0, 0, 3, 2, 1};
`ifdef TIMER_PRESCALE_EN
  int unsigned ps_pat[8] = '{0, 0, 2, 2, 2, 1, 1, 1};
`endif

  initial begin
    // reset held two cycles while writes are attempted
    rst = 1'b0;
    we  = 1'b1;
    be  = 4'hF;
    din = $urandom;
    addr = 2'd0;
    @(posedge clk); #1;
    din = $urandom;
    addr = 2'd1;
    @(posedge clk); #1;
    rst = 1'b1;
    we  = 1'b0;
    be  = '0;
    chk("rst_ctrl",     2'd0, 32'h0, 1'b0);
    step(1); chk("rst_preset",   2'd1, 32'h0, 1'b0);
    step(1); chk("rst_count",    2'd2, 32'h0, 1'b0);
    step(1); chk("rst_prescale", 2'd3, 32'h0, 1'b0);

    // one-shot, PRESET=5, CTRL write is edge 0
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    chk("os_ctrl_en", 2'd0, 32'h9, 1'b0);
    step(2);
    for (int k = 0; k < 5; k++) begin
      chk("os_count", 2'd2, 32'(5 - k), 1'b0);
      step(1);
    end
    chk("os_int_count", 2'd2, 32'h0, 1'b1);
    step(1);
    chk("os_ctrl_en_clr", 2'd0, 32'h8, 1'b1);
    step(3);
    chk("os_irq_held", 2'd2, 32'h0, 1'b1);
    wr(2'd0, 32'h8, 4'hF);
    chk("os_irq_clr", 2'd0, 32'h8, 1'b0);

    // auto-reload, PRESET=3: INT at edges 5,10,15,20
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    step(2);
    for (int e = 2; e <= 22; e++) begin
      chk("ar_count", 2'd2, ar_pat[e % 5], (e >= 5));
      if (e < 22) step(1);
    end
    wr(2'd1, 32'd1, 4'hF);
    chk("ar_pre1_e23", 2'd2, 32'd2, 1'b0);
    step(1); chk("ar_pre1_e24", 2'd2, 32'd1, 1'b0);
    step(1); chk("ar_pre1_e25", 2'd2, 32'd0, 1'b1);
    step(1); chk("ar_pre1_e26", 2'd2, 32'd0, 1'b1);
    step(1); chk("ar_pre1_e27", 2'd2, 32'd1, 1'b1);
    step(1); chk("ar_pre1_e28", 2'd2, 32'd0, 1'b1);
    step(1); chk("ar_pre1_e29", 2'd2, 32'd0, 1'b1);
    step(1); chk("ar_pre1_e30", 2'd2, 32'd1, 1'b1);
    // write lands on the same edge as an INT entry: PEND is set, IM now 0
    wr(2'd0, 32'h0, 4'hF);
    step(2);
    chk("ar_stop_ctrl", 2'd0, 32'h0, 1'b0);

    // masked interrupt, then CTRL write with IM clears PEND
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    step(5);
    chk("mask_ctrl", 2'd0, 32'h0, 1'b0);
    wr(2'd0, 32'h9, 4'hF);
    chk("mask_irq_e6", 2'd0, 32'h9, 1'b0);
    wr(2'd0, 32'h8, 4'hF);
    step(3);
    chk("mask_frozen", 2'd2, 32'd2, 1'b0);

    // byte enables and ignored bits
    wr(2'd1, 32'h0, 4'hF);
    wr(2'd1, 32'hAABBCCDD, 4'b0101);
    chk("be_preset", 2'd1, 32'h00BB00DD, 1'b0);
    wr(2'd2, 32'hFFFFFFFF, 4'hF);
    chk("count_ro", 2'd2, 32'd2, 1'b0);
    wr(2'd0, 32'hFFFFFFF8, 4'hF);
    chk("ctrl_upper", 2'd0, 32'h8, 1'b0);
    wr(2'd0, 32'hFFFFFFF6, 4'b1110);
    chk("ctrl_be0_off", 2'd0, 32'h8, 1'b0);
    wr(2'd0, 32'h0, 4'hF);
    wr(2'd3, 32'hFFFFFF02, 4'hF);
`ifdef TIMER_PRESCALE_EN
    chk("prescale_rb", 2'd3, 32'h02, 1'b0);
`else
    chk("prescale_rb", 2'd3, 32'h0, 1'b0);
`endif

`ifdef TIMER_PRESCALE_EN
    // PRESCALE=2, PRESET=2, auto-reload: INT at edges 8 and 16
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    step(2);
    for (int e = 2; e <= 17; e++) begin
      chk("ps_count", 2'd2, ps_pat[e % 8], (e >= 8));
      step(1);
    end
    wr(2'd0, 32'h0, 4'hF);
    step(4);
    wr(2'd3, 32'h0, 4'hF);
`endif

    // PRESET=0 one-shot: INT 3 cycles after EN write
    wr(2'd1, 32'd0, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    step(2);
    chk("p0_e2", 2'd2, 32'd0, 1'b0);
    step(1);
    chk("p0_int", 2'd2, 32'd0, 1'b1);
    step(1);
    chk("p0_ctrl", 2'd0, 32'h8, 1'b1);
    wr(2'd0, 32'h0, 4'hF);

    // EN cleared while COUNT=4: frozen at 4, no irq
    wr(2'd1, 32'd10, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    step(7);
    wr(2'd0, 32'h8, 4'hF);
    chk("stop_e8", 2'd2, 32'd4, 1'b0);
    step(12);
    chk("stop_frozen", 2'd2, 32'd4, 1'b0);

    // reset mid-count
    wr(2'd1, 32'd5, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    step(3);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    chk("mrst_count", 2'd2, 32'd0, 1'b0);
    step(1); chk("mrst_ctrl", 2'd0, 32'd0, 1'b0);
    step(1); chk("mrst_preset", 2'd1, 32'd0, 1'b0);
    step(10); chk("mrst_noirq", 2'd2, 32'd0, 1'b0);

    step(2);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries unchecked, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
